// File: rtl/pio_svc_pkg.sv
// pio_svc_pkg: shared types and constants for pio_irq_servicer.
//   state_e  : servicer FSM states
//   PIO_ADDR_*: register offsets of the edge-capture PIO slave
//   EVTCNT_W : width of the accepted-event counter
package pio_svc_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_CAP,
        WAIT_CAP,
        CLR,
        RD_DAT,
        WAIT_DAT,
        EMIT
    } state_e;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_CAP  = 2'd3;

    localparam int unsigned EVTCNT_W = 16;

endpackage

// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer: Avalon-MM host servicing one edge-capture PIO slave.
// Programs the slave IRQ mask after reset, then on each IRQ reads the
// edge-capture register, clears it, samples the live input and hands
// {capture, data} downstream over a valid/ready stream.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   m_address/m_chipselect/m_write_n/m_writedata  Avalon-MM host side
//   m_readdata            registered slave readdata (1-cycle latency)
//   irq                   slave level interrupt
//   evt_valid/evt_ready   event stream handshake
//   evt_capture/evt_data  edge_capture value and in_port value of the event
//   evt_count             accepted-event counter
//
// Build option: define PIO_SVC_EVTCNT_EN to get a saturating accepted-event
// counter on evt_count; otherwise evt_count is tied to zero.
module pio_irq_servicer
    import pio_svc_pkg::*;
#(
    parameter int unsigned          DATA_W        = 1,
    parameter logic [DATA_W-1:0]    IRQ_MASK_INIT = DATA_W'(1)
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [1:0]          m_address,
    output logic                m_chipselect,
    output logic                m_write_n,
    output logic [31:0]         m_writedata,
    input  logic [31:0]         m_readdata,
    input  logic                irq,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [DATA_W-1:0]   evt_capture,
    output logic [DATA_W-1:0]   evt_data,
    output logic [EVTCNT_W-1:0] evt_count
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_init_armed;
    logic [DATA_W-1:0]  r_cap;
    logic [DATA_W-1:0]  r_dat;

    logic [1:0]         w_addr;
    logic               w_cs;
    logic               w_write_n;
    logic [31:0]        w_wdata;
    logic               w_evt_valid;
    logic [DATA_W-1:0]  w_rd_field;
    logic               w_unused_rd;

    assign w_rd_field  = m_readdata[DATA_W-1:0];
    assign w_unused_rd = ^m_readdata;

    // r_init_armed holds INIT quiet for the first cycle after reset so the
    // bus outputs show their reset values before the mask write goes out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= INIT;
            r_init_armed <= 1'b0;
            r_cap        <= '0;
            r_dat        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_init_armed <= 1'b1;
            if (r_state == WAIT_CAP) r_cap <= w_rd_field;
            if (r_state == WAIT_DAT) r_dat <= w_rd_field;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr      = PIO_ADDR_DATA;
        w_cs        = 1'b0;
        w_write_n   = 1'b1;
        w_wdata     = '0;
        w_evt_valid = 1'b0;
        case (r_state)
            INIT: begin
                if (r_init_armed) begin
                    w_cs        = 1'b1;
                    w_write_n   = 1'b0;
                    w_addr      = PIO_ADDR_MASK;
                    w_wdata     = 32'(IRQ_MASK_INIT);
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (irq) w_state_nxt = RD_CAP;
            end
            RD_CAP: begin
                w_cs        = 1'b1;
                w_addr      = PIO_ADDR_CAP;
                w_state_nxt = WAIT_CAP;
            end
            WAIT_CAP: begin
                w_addr      = PIO_ADDR_CAP;
                // A zero capture means the IRQ was spurious: skip the clear.
                w_state_nxt = (w_rd_field == '0) ? IDLE : CLR;
            end
            CLR: begin
                w_cs        = 1'b1;
                w_write_n   = 1'b0;
                w_addr      = PIO_ADDR_CAP;
                w_state_nxt = RD_DAT;
            end
            RD_DAT: begin
                w_cs        = 1'b1;
                w_addr      = PIO_ADDR_DATA;
                w_state_nxt = WAIT_DAT;
            end
            WAIT_DAT: begin
                w_addr      = PIO_ADDR_DATA;
                w_state_nxt = EMIT;
            end
            EMIT: begin
                w_evt_valid = 1'b1;
                if (evt_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = INIT;
        endcase
    end

    assign m_address    = w_addr;
    assign m_chipselect = w_cs;
    assign m_write_n    = w_write_n;
    assign m_writedata  = w_wdata;
    assign evt_valid    = w_evt_valid;
    assign evt_capture  = r_cap;
    assign evt_data     = r_dat;

`ifdef PIO_SVC_EVTCNT_EN
    logic [EVTCNT_W-1:0] r_evt_count;

    // Only written on an accepted event, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt_count <= '0;
        end else if (w_evt_valid && evt_ready && (r_evt_count != '1)) begin
            r_evt_count <= r_evt_count + 1'b1;
        end
    end

    assign evt_count = r_evt_count;
`else
    assign evt_count = '0;
`endif

endmodule
